// File: rtl/sigmoid_arbiter.sv
// Round-robin time-sharing of one external Sigmoid_func among NREQ requesters.
// Grant latches the winner's input onto o_sig_in, waits LAT cycles, then returns the result with a done pulse.
module sigmoid_arbiter #(
   parameter int NREQ  = 4,
   parameter int IN_W  = 22,
   parameter int OUT_W = 9,
   parameter int LAT   = 2,
   parameter int ID_W  = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NREQ-1:0]      i_req,
   input  logic [NREQ*IN_W-1:0] i_req_data,
   output logic [NREQ-1:0]      o_done,
   output logic                 o_res_valid,
   output logic [ID_W-1:0]      o_res_id,
   output logic                 o_res_sign,
   output logic                 o_res_ovf,
   output logic [OUT_W-1:0]     o_res_data,
   output logic                 o_busy,
   output logic [IN_W-1:0]      o_sig_in,
   input  logic                 i_sig_sign,
   input  logic                 i_sig_ovf,
   input  logic [OUT_W-1:0]     i_sig_data
);

   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [ID_W-1:0]       r_rr_ptr;
   logic [ID_W-1:0]       r_cur_id;
   logic [CNT_W-1:0]      r_cnt;
   logic [IN_W-1:0]       r_sig_in;
   logic [NREQ-1:0]       r_done;
   logic                  r_res_valid;
   logic [ID_W-1:0]       r_res_id;
   logic                  r_res_sign;
   logic                  r_res_ovf;
   logic [OUT_W-1:0]      r_res_data;

   logic                  w_found;
   logic [ID_W-1:0]       w_winner;
   logic [ID_W:0]         w_sum;
   logic [NREQ*IN_W-1:0]  w_shifted;
   logic [IN_W-1:0]       w_sel_data;

   // Round-robin search: first set request at or above r_rr_ptr, wrapping modulo NREQ.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
         if (w_sum >= (ID_W+1)'(NREQ)) begin
            w_sum = w_sum - (ID_W+1)'(NREQ);
         end else begin
            w_sum = w_sum;
         end
         if (!w_found && i_req[w_sum[ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[ID_W-1:0];
         end else begin
            w_found  = w_found;
         end
      end
      w_shifted  = i_req_data >> (w_winner * IN_W);
      w_sel_data = w_shifted[IN_W-1:0];
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_next_state = ST_WAIT;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_next_state = ST_RELEASE;
            end else begin
               w_next_state = ST_WAIT;
            end
         end
         ST_RELEASE: w_next_state = ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // Grant capture, settle countdown, result capture and pointer advance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr_ptr    <= '0;
         r_cur_id    <= '0;
         r_cnt       <= '0;
         r_sig_in    <= '0;
         r_done      <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res_sign  <= 1'b0;
         r_res_ovf   <= 1'b0;
         r_res_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_cur_id <= w_winner;
                  r_sig_in <= w_sel_data;
                  r_cnt    <= CNT_INIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_res_sign  <= i_sig_sign;
                  r_res_ovf   <= i_sig_ovf;
                  r_res_data  <= i_sig_data;
                  r_res_id    <= r_cur_id;
                  r_done      <= {{(NREQ-1){1'b0}}, 1'b1} << r_cur_id;
                  r_res_valid <= 1'b1;
               end
            end
            ST_RELEASE: begin
               r_done      <= '0;
               r_res_valid <= 1'b0;
               r_rr_ptr    <= (r_cur_id == ID_W'(NREQ - 1)) ? '0 : r_cur_id + ID_W'(1);
            end
            default: begin
               r_done      <= '0;
               r_res_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_done      = r_done;
   assign o_res_valid = r_res_valid;
   assign o_res_id    = r_res_id;
   assign o_res_sign  = r_res_sign;
   assign o_res_ovf   = r_res_ovf;
   assign o_res_data  = r_res_data;
   assign o_sig_in    = r_sig_in;
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter with a combinational Sigmoid_func stub.
// Expected results are hand-computed from the stub mapping data=in[8:0], sign=in[21], ovf=|in[20:12].
module tb_sigmoid_arbiter;

   logic          clk;
   logic          rst;
   logic [3:0]    req;
   logic [87:0]   req_data;
   logic [3:0]    done;
   logic          res_valid;
   logic [1:0]    res_id;
   logic          res_sign;
   logic          res_ovf;
   logic [8:0]    res_data;
   logic          busy;
   logic [21:0]   sig_in;
   logic          sig_sign;
   logic          sig_ovf;
   logic [8:0]    sig_data;

   int n_vec = 0;
   int n_err = 0;

   sigmoid_arbiter dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_req_data  (req_data),
      .o_done      (done),
      .o_res_valid (res_valid),
      .o_res_id    (res_id),
      .o_res_sign  (res_sign),
      .o_res_ovf   (res_ovf),
      .o_res_data  (res_data),
      .o_busy      (busy),
      .o_sig_in    (sig_in),
      .i_sig_sign  (sig_sign),
      .i_sig_ovf   (sig_ovf),
      .i_sig_data  (sig_data)
   );

   assign sig_data = sig_in[8:0];
   assign sig_sign = sig_in[21];
   assign sig_ovf  = |sig_in[20:12];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int port, input logic [21:0] val);
      req_data[port*22 +: 22] = val;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Tick until a done pulse (bounded), then check the completion against hand values.
   task automatic wait_done(input string tag, input int exp_id, input logic [8:0] exp_data,
                            input logic exp_sign, input logic exp_ovf, input int exp_wait);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (done == 4'b0000 && n < 16);
      chk({tag, " wait"},  32'(n), 32'(exp_wait));
      chk({tag, " done"},  32'(done), 32'(4'b0001 << exp_id));
      chk({tag, " valid"}, 32'(res_valid), 32'd1);
      chk({tag, " id"},    32'(res_id), 32'(exp_id));
      chk({tag, " data"},  32'(res_data), 32'(exp_data));
      chk({tag, " sign"},  32'(res_sign), 32'(exp_sign));
      chk({tag, " ovf"},   32'(res_ovf), 32'(exp_ovf));
   endtask

   initial begin
      rst      = 1'b1;
      req      = 4'b0000;
      req_data = '0;
      #1;
      chk("rst done",  32'(done), 32'd0);
      chk("rst busy",  32'(busy), 32'd0);
      chk("rst sigin", 32'(sig_in), 32'd0);
      chk("rst res",   32'({res_valid, res_id, res_sign, res_ovf, res_data}), 32'd0);
      tick();
      rst = 1'b0;

      // 1: single request, latency and capture
      set_data(0, 22'h004100);
      req = 4'b0001;
      tick();
      chk("t1 sigin E0", 32'(sig_in), 32'h004100);
      chk("t1 busy E0",  32'(busy), 32'd1);
      chk("t1 done E0",  32'(done), 32'd0);
      tick();
      chk("t1 busy E1",  32'(busy), 32'd1);
      chk("t1 done E1",  32'(done), 32'd0);
      tick();
      chk("t1 done E2",  32'(done), 32'h1);
      chk("t1 data",     32'(res_data), 32'h100);
      chk("t1 sign",     32'(res_sign), 32'd0);
      chk("t1 ovf",      32'(res_ovf), 32'd1);
      chk("t1 id",       32'(res_id), 32'd0);
      chk("t1 busy E2",  32'(busy), 32'd1);
      req = 4'b0000;
      tick();
      chk("t1 done E3",  32'(done), 32'd0);
      chk("t1 valid E3", 32'(res_valid), 32'd0);
      chk("t1 busy E3",  32'(busy), 32'd0);
      chk("t1 hold",     32'(res_data), 32'h100);

      // 2: all four requesting, round-robin order 0,1,2,3,0
      do_reset();
      set_data(0, 22'h000123);
      set_data(1, 22'h200050);
      set_data(2, 22'h0001FF);
      set_data(3, 22'h001000);
      req = 4'b1111;
      wait_done("t2 #0", 0, 9'h123, 1'b0, 1'b0, 3);
      wait_done("t2 #1", 1, 9'h050, 1'b1, 1'b0, 4);
      wait_done("t2 #2", 2, 9'h1FF, 1'b0, 1'b0, 4);
      wait_done("t2 #3", 3, 9'h000, 1'b0, 1'b1, 4);
      wait_done("t2 #4", 0, 9'h123, 1'b0, 1'b0, 4);
      req = 4'b0000;
      tick();

      // 3: port 3 alone, then pointer wraps so port 0 beats port 1
      do_reset();
      req = 4'b1000;
      wait_done("t3 p3", 3, 9'h000, 1'b0, 1'b1, 3);
      req = 4'b0011;
      wait_done("t3 p0", 0, 9'h123, 1'b0, 1'b0, 4);
      req = 4'b0010;
      wait_done("t3 p1", 1, 9'h050, 1'b1, 1'b0, 4);
      req = 4'b0000;
      tick();

      // 4: input changes after the grant are ignored
      do_reset();
      set_data(1, 22'h3FBF00);
      req = 4'b0010;
      tick();
      set_data(1, 22'h000005);
      chk("t4 sigin E0", 32'(sig_in), 32'h3FBF00);
      tick();
      chk("t4 sigin E1", 32'(sig_in), 32'h3FBF00);
      tick();
      chk("t4 done",     32'(done), 32'h2);
      chk("t4 sign",     32'(res_sign), 32'd1);
      chk("t4 data",     32'(res_data), 32'h100);
      chk("t4 ovf",      32'(res_ovf), 32'd1);
      chk("t4 sigin E2", 32'(sig_in), 32'h3FBF00);
      req = 4'b0000;
      tick();
      tick();
      chk("t4 sigin idle", 32'(sig_in), 32'h3FBF00);

      // 5: reset during WAIT abandons the op; pending request re-granted afterwards
      do_reset();
      set_data(2, 22'h000077);
      req = 4'b0100;
      tick();
      chk("t5 busy",     32'(busy), 32'd1);
      chk("t5 sigin",    32'(sig_in), 32'h000077);
      rst = 1'b1;
      #1;
      chk("t5 async",    32'({busy, done, res_valid, res_id, res_sign, res_ovf, res_data}), 32'd0);
      chk("t5 async sigin", 32'(sig_in), 32'd0);
      tick();
      chk("t5 rst done", 32'(done), 32'd0);
      rst = 1'b0;
      wait_done("t5 regrant", 2, 9'h077, 1'b0, 1'b0, 3);
      req = 4'b0000;
      tick();

      // 6: request dropped during WAIT still completes exactly once
      set_data(0, 22'h000042);
      req = 4'b0001;
      tick();
      req = 4'b0000;
      wait_done("t6 drop", 0, 9'h042, 1'b0, 1'b0, 2);
      tick();
      chk("t6 done off", 32'(done), 32'd0);
      tick();
      chk("t6 idle busy", 32'(busy), 32'd0);
      chk("t6 idle done", 32'(done), 32'd0);
      tick();
      chk("t6 idle busy2", 32'(busy), 32'd0);
      chk("t6 hold data",  32'(res_data), 32'h042);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sigmoid_arbiter.md
Name: sigmoid_arbiter

Overview:
- Time-shares one Sigmoid_func instance among NREQ requesters, e.g. the neuron accumulators of a layer.
- Round-robin arbitration picks one request at a time.
- The winner's 22-bit signed pre-activation is registered onto the shared unit's input.
- The block waits a fixed settle latency, captures {sign, ovf, data} and returns it with a one-cycle done pulse to the winner.
- Sits between the accumulator array and the single sigmoid datapath; the sigmoid unit itself stays outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IN_W, 22, signed input width to Sigmoid_func.
- OUT_W, 9, data width returned by Sigmoid_func.
- LAT, 2, clock cycles from sig_in change to a valid sigmoid output (LAT >= 1).
- ID_W, 2, requester index width (>= clog2(NREQ)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_data  in  NREQ*IN_W  flattened signed inputs; requester i occupies bits [i*IN_W +: IN_W].
- done  out  NREQ  one-hot, one-cycle completion pulse to the granted requester.
- res_valid  out  1  high in the same cycle as done.
- res_id  out  ID_W  index of the requester being completed.
- res_sign  out  1  captured sign.
- res_ovf  out  1  captured overflow.
- res_data  out  OUT_W  captured sigmoid value.
- busy  out  1  high whenever state != IDLE.
- sig_in  out  IN_W  registered drive to Sigmoid_func input.
- sig_sign  in  1  from Sigmoid_func.
- sig_ovf  in  1  from Sigmoid_func.
- sig_data  in  OUT_W  from Sigmoid_func.

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, rr_ptr=0, cur_id=0, cnt=0.
  - sig_in=0, done=0, res_valid=0.
  - res_id=0, res_sign=0, res_ovf=0, res_data=0, busy=0.
- Reset asserted mid-operation: the in-flight op is abandoned, no done pulse, nothing captured.
- FSM states: IDLE, WAIT, RELEASE.
- IDLE:
  - Stays in IDLE if req == 0.
  - Otherwise the winner is the first set bit of req, searching from rr_ptr upward with wrap modulo NREQ.
  - At that edge: cur_id <= winner, sig_in <= req_data slice[winner], cnt <= LAT-1, state <= WAIT.
- WAIT:
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: res_sign/res_ovf/res_data <= sig_sign/sig_ovf/sig_data.
  - Also at cnt == 0: res_id <= cur_id, done[cur_id] <= 1, res_valid <= 1, state <= RELEASE.
- RELEASE (done/res_valid high during this cycle):
  - done <= 0, res_valid <= 0.
  - rr_ptr <= (cur_id+1) mod NREQ, state <= IDLE.
- Latency: with req sampled at edge E0, done is high in the cycle following edge E(LAT).
- Throughput: one operation per LAT+2 cycles.
- Input sampling:
  - req_data is sampled only at the grant edge; later changes are ignored.
  - sig_in holds its value until the next grant.
- Requester protocol:
  - Hold req until done is seen, then deassert on the edge that ends the done cycle.
  - req still high in IDLE after RELEASE is a new request.
  - Because rr_ptr advanced, any other pending requester wins first.
- req withdrawn while its op is in WAIT: the op still completes and done still pulses. Requesters must tolerate this.
- Requests arriving during WAIT/RELEASE are not sampled; they are arbitrated in the next IDLE.
- rr_ptr wrap: cur_id=NREQ-1 gives rr_ptr=0.
- res_* hold their last captured value after RELEASE until the next capture.
- Exactly one done bit is high at a time; done is never high outside RELEASE.
- Sigmoid_func is treated as combinational with a settle time of at most LAT cycles.

Test Plan:
1. Reset, then req=4'b0001 with data 22'sd16640 (0x004100); stub sets sig_data=sig_in[8:0], sig_sign=sig_in[21], sig_ovf=|sig_in[20:12].
   -> sig_in=0x004100 after E0; done=4'b0001 after E2; res_data=0x100, res_sign=0, res_ovf=1, res_id=0; busy high for 3 cycles.
2. req=4'b1111 held continuously, distinct data per port.
   -> completion order 0,1,2,3,0; done pulses 4 cycles apart (LAT=2); each res_data matches that port's data.
3. Only port 3 requests, then port 0 in the following IDLE.
   -> grant 3, then rr_ptr wraps to 0 and port 0 is granted.
4. Port 1 data changes from -22'sd16640 to +5 one cycle after grant.
   -> result reflects -16640 (res_sign=1); sig_in stays 0x3FBF00 through WAIT.
5. rst asserted during WAIT, port 2 granted.
   -> all outputs 0 immediately, no done pulse; after release, a pending req=4'b0100 is re-granted and completes normally.
6. Port 0 drops req during WAIT.
   -> done[0] still pulses once; the next IDLE with req=0 remains idle and busy=0.
